l2t_sii_req_rcv: RTL and testbench
==================================

// Module: l2t_sii_req_rcv
// PURPOSE
// L2T-side receiver for the SII->L2T inbound request path, one instance per L2 bank.
// Captures the 32-bit request stream announced by sii_l2t_req_vld: two header words, then 0/2/16 data words.
// Reassembles each packet into a 64-bit header plus payload and queues it in an input queue (IQ) and a write buffer (WIB).
// Returns the dequeue pulses (l2t_sii_iq_dequeue, l2t_sii_wib_dequeue) that SII uses as flow-control credits.
// PARAMETERS
// IQ_DEPTH   4  IQ entries (header + 64b WR8 data); power of 2, >=2
// WIB_DEPTH  2  WIB entries (one 64-byte WRI line each); power of 2, >=1
// PORTS
// iol2clk              in   1    I/O-L2 clock, all state on rising edge
// rst_l                in   1    asynchronous active-low reset
// sii_l2t_req_vld      in   1    packet start strobe (1 cycle, before header)
// sii_l2t_req          in   32   header/data word stream
// iq_pop               in   1    downstream consumes IQ head (legal only when iq_vld)
// iq_vld               out  1    IQ non-empty
// iq_hdr               out  64   IQ head header {hi,lo}
// iq_data              out  64   IQ head WR8 data {w0,w1}; 0 for RD/WRI
// wib_pop              in   1    downstream consumes WIB head (legal only when wib_vld)
// wib_vld              out  1    WIB non-empty
// wib_data             out  512  WIB head line, word0 in [511:480]
// l2t_sii_iq_dequeue   out  1    1-cycle credit pulse per IQ pop
// l2t_sii_wib_dequeue  out  1    1-cycle credit pulse per WIB pop
// ovf_err              out  1    sticky: packet dropped, required queue full
// proto_err            out  1    sticky: vld mid-packet or illegal cmd
// BEHAVIOUR
// - Reset: all outputs 0, queues empty, FSM IDLE, sticky errors cleared; asserting rst_l low mid-packet discards that packet.
// - Cmd decode = header[63:61]: 001 RD (0 data words), 100 WR8 (2 words), 010 WRI (16 words).
//   Any other cmd: set proto_err, consume the header only, queue nothing.
// - FSM: IDLE -vld-> HDR0 (capture hi) -> HDR1 (capture lo, decode cmd).
//   After HDR1, RD and illegal cmds return to IDLE; WR8/WRI go to DATA with cnt = words-1.
//   DATA decrements cnt each cycle and returns to IDLE after cnt==0.
// - Commit: registered push 1 cycle after the last packet word, so iq_vld/wib_vld rise 2 cycles after that word.
//   RD/WR8 push IQ only. WRI pushes its header to IQ and its line to WIB in the same cycle.
// - Space check at HDR1, using occupancy that includes pending pushes and same-cycle pops.
//   If the needed IQ slot (and WIB slot for WRI) is missing, the whole packet is drained without a push and ovf_err is set.
// - Back-to-back: vld is legal in the cycle after the last packet word; the FSM re-enters HDR0 with no bubble.
// - vld while in HDR0/HDR1/DATA: set proto_err, ignore the strobe, continue the current packet.
// - Pops: iq_pop or wib_pop removes the head at the edge. The matching *_dequeue is high exactly the next cycle.
//   Push and pop in the same cycle are both honoured; occupancy is unchanged.
// - Pop when empty: ignored, no dequeue pulse. FIFO pointers wrap modulo depth with an extra wrap bit for full/empty.
// - Outputs are registered; iq_hdr/iq_data/wib_data are valid only while the matching *_vld is high.
// TESTING
// - RD: vld; hdr 2000_0000, 0000_1040 -> iq_vld 2 cycles after hdr lo, iq_hdr=2000_0000_0000_1040, iq_data=0; pop -> iq_dequeue 1 cycle later.
// - WR8: hdr 8000_0000, 0000_0008; data DEAD_BEEF, CAFE_F00D -> iq_data=DEADBEEF_CAFEF00D; wib_vld stays 0.
// - WRI: 16 words 0..15 -> iq_vld and wib_vld rise together, wib_data[511:480]=0, [31:0]=15; wib_pop -> wib_dequeue pulse.
// - Overflow: 5 RDs with IQ_DEPTH=4, no pops -> 4 queued, 5th dropped, ovf_err=1; 1 pop -> exactly one iq_dequeue.
// - Protocol: vld in DATA of a WRI -> proto_err=1, WRI still queued intact; hdr E000_0000 -> proto_err, nothing queued.
// - Reset: rst_l low during WRI word 7 -> all outputs 0 at once; fresh RD after release queues normally.

Source files
------------

// File: rtl/l2t_sii_req_rcv_if.sv
// SII->L2T inbound request bundle for one L2 bank.
// Carries the request word stream, the IQ/WIB head views and pops, the
// credit-return pulses and the sticky error flags.
//   master : SII side plus downstream consumer (drives stream and pops)
//   slave  : l2t_sii_req_rcv (drives queue heads, credits, errors)
interface l2t_sii_req_rcv_if;
  logic         sii_l2t_req_vld;
  logic [31:0]  sii_l2t_req;
  logic         iq_pop;
  logic         iq_vld;
  logic [63:0]  iq_hdr;
  logic [63:0]  iq_data;
  logic         wib_pop;
  logic         wib_vld;
  logic [511:0] wib_data;
  logic         l2t_sii_iq_dequeue;
  logic         l2t_sii_wib_dequeue;
  logic         ovf_err;
  logic         proto_err;

  modport master (
    output sii_l2t_req_vld, sii_l2t_req, iq_pop, wib_pop,
    input  iq_vld, iq_hdr, iq_data, wib_vld, wib_data,
           l2t_sii_iq_dequeue, l2t_sii_wib_dequeue, ovf_err, proto_err
  );

  modport slave (
    input  sii_l2t_req_vld, sii_l2t_req, iq_pop, wib_pop,
    output iq_vld, iq_hdr, iq_data, wib_vld, wib_data,
           l2t_sii_iq_dequeue, l2t_sii_wib_dequeue, ovf_err, proto_err
  );
endinterface

// File: rtl/l2t_sii_req_rcv.sv
// L2T-side receiver for SII inbound requests (one per L2 bank).
// Reassembles the 32-bit word stream (2 header words + 0/2/16 data words)
// into a 64-bit header plus payload, queues it in the IQ (and, for WRI, the
// WIB), and returns one-cycle dequeue pulses as credits to SII.
// Ports:
//   iol2clk : clock, all state on rising edge
//   rst_l   : asynchronous active-low reset
//   sii     : request bundle (slave side), see l2t_sii_req_rcv_if

// Simple FIFO: pointers carry an extra wrap bit, so occupancy is wr-rd.
module l2t_sii_req_rcv_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = (AW > 0) ? AW : 1;

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [W-1:0]  mem [DEPTH];

  if (AW == 0) begin : g_one
    assign wr_idx = '0;
    assign rd_idx = '0;
  end else begin : g_many
    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= din;
  end

  assign dout = mem[rd_idx];
  assign cnt  = wr_ptr - rd_ptr;
endmodule

module l2t_sii_req_rcv #(
  parameter int IQ_DEPTH  = 4,
  parameter int WIB_DEPTH = 2
) (
  input  logic          iol2clk,
  input  logic          rst_l,
  l2t_sii_req_rcv_if.slave sii
);
  localparam int IQ_AW  = $clog2(IQ_DEPTH);
  localparam int WIB_AW = $clog2(WIB_DEPTH);
  localparam logic [2:0] CMD_RD  = 3'b001;
  localparam logic [2:0] CMD_WR8 = 3'b100;
  localparam logic [2:0] CMD_WRI = 3'b010;

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_t;
  state_t state, state_nxt;

  logic [31:0]  hdr_hi, hdr_lo;
  logic [511:0] line;          // data shift register, word0 ends up at the top
  logic [3:0]   cnt;
  logic         is_wri, is_wr8, drop;
  logic         push_iq, push_wib;
  logic         iq_vld_q, wib_vld_q, iq_deq, wib_deq, ovf_q, proto_q;

  logic [IQ_AW:0]    iq_cnt;
  logic [WIB_AW:0]   wib_cnt;
  logic [IQ_AW+1:0]  iq_occ;
  logic [WIB_AW+1:0] wib_occ;
  logic [127:0]      iq_head;
  logic [511:0]      wib_head;

  logic [2:0] cmd;
  logic       is_rd_c, is_wr8_c, is_wri_c, legal, iq_room, wib_room, accept;
  logic       iq_pop_ok, wib_pop_ok, last_word, commit;

  assign iq_pop_ok  = sii.iq_pop  && iq_vld_q;
  assign wib_pop_ok = sii.wib_pop && wib_vld_q;

  // Occupancy as it will be after this edge: counts the push in flight and
  // any pop happening in the same cycle. Drives both the space check and vld.
  assign iq_occ  = {1'b0, iq_cnt} + (IQ_AW+2)'(push_iq) - (IQ_AW+2)'(iq_pop_ok);
  assign wib_occ = {1'b0, wib_cnt} + (WIB_AW+2)'(push_wib) - (WIB_AW+2)'(wib_pop_ok);
  assign iq_room  = iq_occ  < (IQ_AW+2)'(IQ_DEPTH);
  assign wib_room = wib_occ < (WIB_AW+2)'(WIB_DEPTH);

  // Decode happens in HDR1, when hdr_hi already holds header[63:32].
  assign cmd      = hdr_hi[31:29];
  assign is_rd_c  = (cmd == CMD_RD);
  assign is_wr8_c = (cmd == CMD_WR8);
  assign is_wri_c = (cmd == CMD_WRI);
  assign legal    = is_rd_c || is_wr8_c || is_wri_c;
  assign accept   = legal && iq_room && (!is_wri_c || wib_room);

  always_comb begin
    state_nxt = state;
    last_word = 1'b0;
    case (state)
      IDLE: if (sii.sii_l2t_req_vld) state_nxt = HDR0;
      HDR0: state_nxt = HDR1;
      HDR1: begin
        if (!legal || is_rd_c) begin
          state_nxt = IDLE;
          last_word = is_rd_c;
        end else begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (cnt == 4'd0) begin
          state_nxt = IDLE;
          last_word = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RD completes in HDR1 so its accept decision is used directly; data
  // packets use the decision latched into drop at HDR1.
  assign commit = last_word && ((state == HDR1) ? accept : !drop);

  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      hdr_hi    <= '0;
      hdr_lo    <= '0;
      line      <= '0;
      cnt       <= '0;
      is_wri    <= 1'b0;
      is_wr8    <= 1'b0;
      drop      <= 1'b0;
      push_iq   <= 1'b0;
      push_wib  <= 1'b0;
      iq_vld_q  <= 1'b0;
      wib_vld_q <= 1'b0;
      iq_deq    <= 1'b0;
      wib_deq   <= 1'b0;
      ovf_q     <= 1'b0;
      proto_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        HDR0: hdr_hi <= sii.sii_l2t_req;
        HDR1: begin
          hdr_lo <= sii.sii_l2t_req;
          is_wri <= is_wri_c;
          is_wr8 <= is_wr8_c;
          drop   <= !accept;
          cnt    <= is_wri_c ? 4'd15 : 4'd1;
        end
        DATA: begin
          line <= {line[479:0], sii.sii_l2t_req};
          cnt  <= cnt - 4'd1;
        end
        default: ;
      endcase
      // Header/line registers stay stable through the push cycle: the next
      // packet cannot reach HDR0 before then.
      push_iq  <= commit;
      push_wib <= commit && (state == DATA) && is_wri;
      iq_vld_q  <= (iq_occ  != '0);
      wib_vld_q <= (wib_occ != '0);
      iq_deq    <= iq_pop_ok;
      wib_deq   <= wib_pop_ok;
      if (state == HDR1 && legal && !accept) ovf_q <= 1'b1;
      if ((sii.sii_l2t_req_vld && state != IDLE) || (state == HDR1 && !legal))
        proto_q <= 1'b1;
    end
  end

  l2t_sii_req_rcv_fifo #(.DEPTH(IQ_DEPTH), .W(128)) u_iq (
    .clk   (iol2clk),
    .rst_n (rst_l),
    .push  (push_iq),
    .pop   (iq_pop_ok),
    .din   ({hdr_hi, hdr_lo, (is_wr8 ? line[63:0] : 64'd0)}),
    .dout  (iq_head),
    .cnt   (iq_cnt)
  );

  l2t_sii_req_rcv_fifo #(.DEPTH(WIB_DEPTH), .W(512)) u_wib (
    .clk   (iol2clk),
    .rst_n (rst_l),
    .push  (push_wib),
    .pop   (wib_pop_ok),
    .din   (line),
    .dout  (wib_head),
    .cnt   (wib_cnt)
  );

  // Heads are forced to 0 while empty so nothing stale leaks out after reset.
  assign sii.iq_vld              = iq_vld_q;
  assign sii.iq_hdr              = iq_vld_q  ? iq_head[127:64] : 64'd0;
  assign sii.iq_data             = iq_vld_q  ? iq_head[63:0]   : 64'd0;
  assign sii.wib_vld             = wib_vld_q;
  assign sii.wib_data            = wib_vld_q ? wib_head        : 512'd0;
  assign sii.l2t_sii_iq_dequeue  = iq_deq;
  assign sii.l2t_sii_wib_dequeue = wib_deq;
  assign sii.ovf_err             = ovf_q;
  assign sii.proto_err           = proto_q;
endmodule

// File: tb/tb_l2t_sii_req_rcv.sv
// Randomized bench for l2t_sii_req_rcv: random RD/WR8/WRI/illegal packets,
// random gaps (including back-to-back), random pops (including pops on
// empty queues), occasional stray strobes mid-packet, and a reset in the
// middle of a WRI. A transaction-level queue model predicts every output.
module tb_l2t_sii_req_rcv;
  localparam int IQ_DEPTH  = 4;
  localparam int WIB_DEPTH = 2;
  localparam int N_CYC     = 3000;
  localparam int RST_AT    = 2000;

  logic iol2clk = 1'b0;
  logic rst_l   = 1'b0;
  always #5 iol2clk = ~iol2clk;

  l2t_sii_req_rcv_if sii ();

  l2t_sii_req_rcv #(.IQ_DEPTH(IQ_DEPTH), .WIB_DEPTH(WIB_DEPTH)) dut (
    .iol2clk (iol2clk),
    .rst_l   (rst_l),
    .sii     (sii.slave)
  );

  typedef struct {
    logic [63:0] hdr;
    logic [63:0] data;
    int          vis;
  } iq_ent_t;
  typedef struct {
    logic [511:0] line;
    int           vis;
  } wib_ent_t;

  iq_ent_t  iq_q[$];
  wib_ent_t wib_q[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model state
  logic        exp_ovf, exp_proto, exp_iq_deq, exp_wib_deq;
  logic [31:0] pw[18];
  logic [511:0] pline;
  int          nw, pos, gap;
  bit          active, accepted, rst_done, force_rd;

  task automatic chk_zero(input string tag);
    chk({tag, "_iq_vld"},  512'(sii.iq_vld), 512'd0);
    chk({tag, "_iq_hdr"},  512'(sii.iq_hdr), 512'd0);
    chk({tag, "_iq_data"}, 512'(sii.iq_data), 512'd0);
    chk({tag, "_wib_vld"}, 512'(sii.wib_vld), 512'd0);
    chk({tag, "_wib_data"}, sii.wib_data, 512'd0);
    chk({tag, "_iq_deq"},  512'(sii.l2t_sii_iq_dequeue), 512'd0);
    chk({tag, "_wib_deq"}, 512'(sii.l2t_sii_wib_dequeue), 512'd0);
    chk({tag, "_ovf"},     512'(sii.ovf_err), 512'd0);
    chk({tag, "_proto"},   512'(sii.proto_err), 512'd0);
  endtask

  task automatic model_clear();
    iq_q.delete();
    wib_q.delete();
    exp_ovf = 0; exp_proto = 0; exp_iq_deq = 0; exp_wib_deq = 0;
    active = 0; pos = 0; gap = 0;
  endtask

  // Build one packet: header hi/lo then its data words.
  task automatic gen_pkt(input bit want_wri, input bit want_rd);
    int r;
    logic [2:0] c;
    logic [2:0] bad[5];
    bad = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    r = int'($urandom_range(0, 9));
    if (want_wri)      c = 3'b010;
    else if (want_rd)  c = 3'b001;
    else if (r < 4)    c = 3'b001;
    else if (r < 6)    c = 3'b100;
    else if (r < 8)    c = 3'b010;
    else               c = bad[$urandom_range(0, 4)];
    pw[0] = {c, 29'($urandom)};
    pw[1] = $urandom;
    nw = (c == 3'b100) ? 4 : (c == 3'b010) ? 18 : 2;
    pline = '0;
    for (int i = 2; i < nw; i++) begin
      pw[i] = $urandom;
      if (c == 3'b010) pline[511 - 32*(i-2) -: 32] = pw[i];
    end
  endtask

  initial begin
    bit ipop, wpop, vld, cur_wri, do_rst;
    logic [31:0] req;
    logic [2:0] c;
    int occ_iq, occ_wib;
    iq_ent_t ie;
    wib_ent_t we;

    sii.sii_l2t_req_vld = 1'b0;
    sii.sii_l2t_req     = '0;
    sii.iq_pop          = 1'b0;
    sii.wib_pop         = 1'b0;
    model_clear();
    rst_done = 0; force_rd = 0;

    #1;
    chk_zero("reset");
    @(negedge iol2clk);
    rst_l = 1'b1;

    for (int k = 0; k < N_CYC; k++) begin
      @(negedge iol2clk);
      rst_l = 1'b1;

      // compare outputs against the model
      chk("iq_vld", 512'(sii.iq_vld), 512'(iq_q.size() > 0 && iq_q[0].vis <= k));
      chk("wib_vld", 512'(sii.wib_vld), 512'(wib_q.size() > 0 && wib_q[0].vis <= k));
      if (iq_q.size() > 0 && iq_q[0].vis <= k) begin
        chk("iq_hdr", 512'(sii.iq_hdr), 512'(iq_q[0].hdr));
        chk("iq_data", 512'(sii.iq_data), 512'(iq_q[0].data));
      end
      if (wib_q.size() > 0 && wib_q[0].vis <= k)
        chk("wib_data", sii.wib_data, wib_q[0].line);
      chk("iq_deq", 512'(sii.l2t_sii_iq_dequeue), 512'(exp_iq_deq));
      chk("wib_deq", 512'(sii.l2t_sii_wib_dequeue), 512'(exp_wib_deq));
      chk("ovf_err", 512'(sii.ovf_err), 512'(exp_ovf));
      chk("proto_err", 512'(sii.proto_err), 512'(exp_proto));

      // reset while data word 7 of a WRI is on the bus
      cur_wri = active && (nw == 18);
      do_rst  = !rst_done && k >= RST_AT && cur_wri && pos == 9;
      if (do_rst) begin
        rst_l = 1'b0;
        sii.sii_l2t_req_vld = 1'b0;
        sii.iq_pop  = 1'b0;
        sii.wib_pop = 1'b0;
        #1;
        chk_zero("mid_wri_rst");
        model_clear();
        rst_done = 1;
        force_rd = 1;
        continue;
      end

      // pops (random, sometimes on an empty queue)
      ipop = ($urandom_range(0, 2) == 0);
      wpop = ($urandom_range(0, 2) == 0);
      exp_iq_deq = 0;
      exp_wib_deq = 0;
      if (ipop && iq_q.size() > 0 && iq_q[0].vis <= k) begin
        void'(iq_q.pop_front());
        exp_iq_deq = 1;
      end
      if (wpop && wib_q.size() > 0 && wib_q[0].vis <= k) begin
        void'(wib_q.pop_front());
        exp_wib_deq = 1;
      end

      // request stream
      vld = 0;
      req = $urandom;
      if (!active) begin
        if (gap > 0) gap--;
        else begin
          gen_pkt(!rst_done && k >= RST_AT, force_rd);
          force_rd = 0;
          vld = 1;
          active = 1;
          pos = 0;
        end
      end else begin
        req = pw[pos];
        c = pw[0][31:29];
        if (pos == 1) begin
          if (!(c == 3'b001 || c == 3'b100 || c == 3'b010)) begin
            exp_proto = 1;
            accepted = 0;
          end else begin
            occ_iq  = iq_q.size();
            occ_wib = wib_q.size();
            accepted = (occ_iq < IQ_DEPTH) && (c != 3'b010 || occ_wib < WIB_DEPTH);
            if (!accepted) exp_ovf = 1;
          end
        end
        if (pos == nw - 1) begin
          if (accepted) begin
            ie.hdr  = {pw[0], pw[1]};
            ie.data = (c == 3'b100) ? {pw[2], pw[3]} : 64'd0;
            ie.vis  = k + 2;
            iq_q.push_back(ie);
            if (c == 3'b010) begin
              we.line = pline;
              we.vis  = k + 2;
              wib_q.push_back(we);
            end
          end
          active = 0;
          gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
        end
        pos++;
        // stray strobe inside a packet
        if ($urandom_range(0, 39) == 0) begin
          vld = 1;
          exp_proto = 1;
        end
      end

      sii.sii_l2t_req_vld = vld;
      sii.sii_l2t_req     = req;
      sii.iq_pop          = ipop;
      sii.wib_pop         = wpop;
    end

    chk("rst_seen", 512'(rst_done), 512'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
